cascade_lut_pipe: RTL
=====================

// Module: cascade_lut_pipe
// PURPOSE
//  Parametrised, clocked successor to the two-circuit switch cascade. Stage 0 evaluates a
//  4-input function of switches; each later stage evaluates a 4-input function of the previous
//  stage's output plus 3 new switches. Adds switch sync/debounce, per-stage pipeline registers,
//  a valid/ready sample handshake and registered LED outputs. Sits between board switches and LEDs.
// PARAMETERS
//  STAGES      2                  number of cascaded stages (>=1); NSW = 3*STAGES+1 switches
//  LUT_INIT    {STAGES{16'h8000}} stage k truth table = LUT_INIT[16k +: 16]; default AND4
//  DEBOUNCE    4                  cycles a synced switch must be stable before accepted (>=1)
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  sw         in   NSW      raw asynchronous switch inputs
//  in_valid   in   1        request: evaluate current debounced switch snapshot
//  in_ready   out  1        snapshot accepted when in_valid & in_ready
//  out_valid  out  1        result beat available on result
//  out_ready  in   1        consumer takes beat when out_valid & out_ready
//  result     out  STAGES   per-stage outputs of the beat (bit k = stage k Y)
//  led        out  STAGES   last transferred result, held
//  changed    out  1        1-cycle pulse: transferred result differs from previous led
// BEHAVIOUR
//  Reset (async assert, sync-released use): all sync/debounce flops, counters, stage valids,
//   result, led, changed -> 0; debounced switch vector -> 0; in_ready = 1 out of reset.
//  Sync: each sw bit through 2 flops. Debounce per bit: counter clears when synced bit equals
//   debounced bit; else increments; when it reaches DEBOUNCE-1 and still differs, debounced bit
//   takes synced value and counter clears. Stable change visible at 2+DEBOUNCE cycles.
//   Pulses shorter than DEBOUNCE cycles never propagate.
//  Switch mapping: stage 0 uses A=db[0],B=db[1],C=db[2],D=db[3]. Stage k>=1: A=Y(k-1),
//   B=db[3k+1],C=db[3k+2],D=db[3k+3]. Y = LUT_k[{D,C,B,A}] (A is LSB of index).
//  Pipeline: advance = ~out_valid | out_ready; in_ready = advance (combinational).
//   On accept, full debounced snapshot is captured with stage 0; snapshot travels with the item
//   so later stages use switches as captured, not as currently set.
//   Stage k registers Y(k) and all earlier Y bits; valid bit per stage shifts on advance.
//   Latency: accept at cycle t -> out_valid, result at t+STAGES. Throughput 1/cycle when
//   out_ready=1. Global stall: nothing moves while out_valid & ~out_ready; bubbles not collapsed.
//   result stable while out_valid & ~out_ready. in_valid while ~in_ready: snapshot not taken.
//  Transfer (out_valid & out_ready): led <= result next edge; changed pulses same edge iff
//   result != old led. No transfer: led holds, changed = 0.
//  Reset mid-operation: all in-flight items discarded, no out_valid after release until new accept.
//  Switch change during in-flight items: does not affect those items.
// TESTING
//  1 Reset: rst_n=0 with sw=7'h7F, in_valid=1 -> led=0,out_valid=0,changed=0; in_ready=1 after release.
//  2 Debounce (DEBOUNCE=4): sw[0] glitch 3 cycles -> db unchanged; held 10 cycles -> db[0]=1 at cycle 6.
//  3 STAGES=2 AND: sw=7'h7F debounced, in_valid 1 cycle -> result=2'b11 after 2 cycles,
//    led=2'b11, changed=1; then sw=7'h6F -> result=2'b01, changed=1; repeat -> changed=0.
//  4 Backpressure: out_ready=0, issue 3 accepts of alternating snapshots -> 2 in flight,
//    in_ready=0, no loss; release out_ready -> beats in issue order, result stable while stalled.
//  5 Reset mid-flight: assert rst_n=0 with 2 items in pipe -> after release no out_valid, led=0.
//  6 STAGES=3, LUT_INIT={3{16'hFFFE}} (OR4): sw=10'h000 -> 3'b000; sw=10'h001 -> 3'b111.

Source files
------------

// File: rtl/cascade_lut_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_lut_pipe_if
//  Description : Bundle for the cascade_lut_pipe switch/LED path. It carries the
//                raw switch vector, the sample request handshake
//                (in_valid/in_ready), the result beat handshake
//                (out_valid/out_ready/result) and the held LED state
//                (led/changed).
//                  master : switch/request source and result consumer
//                  slave  : cascade_lut_pipe
//  Parameters  : STAGES - number of cascaded stages; NSW = 3*STAGES+1 switches
//  Revision    : 1.0 - initial release
// ============================================================================
interface cascade_lut_pipe_if #(
    parameter int STAGES = 2
);
    localparam int NSW = 3 * STAGES + 1;

    logic [NSW-1:0]    sw;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [STAGES-1:0] result;
    logic [STAGES-1:0] led;
    logic              changed;

    modport master (
        output sw, in_valid, out_ready,
        input  in_ready, out_valid, result, led, changed
    );

    modport slave (
        input  sw, in_valid, out_ready,
        output in_ready, out_valid, result, led, changed
    );
endinterface
`default_nettype wire

// File: rtl/cascade_lut_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_lut_pipe
//  Description : Clocked cascade of 4-input LUT stages driven by board switches.
//                Stage 0 evaluates LUT_0 over db[3:0]; stage k>=1 evaluates LUT_k
//                over {db[3k+3], db[3k+2], db[3k+1], Y(k-1)}. Switches are
//                synchronised and debounced, a request samples the debounced
//                vector, the sample walks one stage per cycle with its own switch
//                snapshot, and transferred results are held on the LEDs.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - cascade_lut_pipe_if.slave:
//                          sw        in  raw switches
//                          in_valid  in  sample request
//                          in_ready  out request accepted when both high
//                          out_valid out result beat present
//                          out_ready in  consumer takes beat
//                          result    out per-stage Y bits of the beat
//                          led       out last transferred result
//                          changed   out pulse when a transfer changes led
//  Parameters  : STAGES   - stage count (>=1)
//                LUT_INIT - stage k truth table at LUT_INIT[16k +: 16]
//                DEBOUNCE - cycles of stable input before acceptance (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module cascade_lut_pipe #(
    parameter int                   STAGES   = 2,
    parameter logic [16*STAGES-1:0] LUT_INIT = {STAGES{16'h8000}},
    parameter int                   DEBOUNCE = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    cascade_lut_pipe_if.slave bus
);

    localparam int             NSW       = 3 * STAGES + 1;
    localparam int             c_CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE - 1);

    // ------------------------------------------------------------------
    // Switch synchroniser and per-bit debounce
    // ------------------------------------------------------------------
    logic [NSW-1:0]            r_sync1;
    logic [NSW-1:0]            r_sync2;
    logic [NSW-1:0]            r_db;
    logic [NSW-1:0][c_CW-1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.sw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit is accepted only after it has disagreed with the debounced
    // value for DEBOUNCE consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db  <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NSW; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: one register stage per LUT, globally stalled by the output
    // ------------------------------------------------------------------
    logic w_advance;
    logic w_xfer;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam logic [15:0] c_LUT = LUT_INIT[16*k +: 16];

            logic              r_vld;
            logic [STAGES-1:0] r_res;
            logic [NSW-1:0]    r_snap;

            logic [3:0]        w_idx;
            logic              w_vld_in;
            logic [NSW-1:0]    w_snap_in;
            logic [STAGES-1:0] w_res_in;
            logic              w_y;

            if (k == 0) begin : g_first
                // The request samples the live debounced vector; that sample
                // then travels with the item for use by later stages.
                assign w_idx     = r_db[3:0];
                assign w_vld_in  = bus.in_valid;
                assign w_snap_in = r_db;
                assign w_res_in  = '0;
            end else begin : g_next
                assign w_idx     = {g_stage[k-1].r_snap[3*k+3],
                                    g_stage[k-1].r_snap[3*k+2],
                                    g_stage[k-1].r_snap[3*k+1],
                                    g_stage[k-1].r_res[k-1]};
                assign w_vld_in  = g_stage[k-1].r_vld;
                assign w_snap_in = g_stage[k-1].r_snap;
                assign w_res_in  = g_stage[k-1].r_res;
            end

            assign w_y = c_LUT[w_idx];

            // Data is loaded only for real items so a bubble leaves the
            // previous contents (and the visible result) untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_res  <= '0;
                    r_snap <= '0;
                end else if (w_advance) begin
                    r_vld <= w_vld_in;
                    if (w_vld_in) begin
                        r_snap <= w_snap_in;
                        r_res  <= w_res_in | (STAGES'(w_y) << k);
                    end
                end
            end

            if (k == STAGES - 1) begin : g_last
                // The final stage has no successor to consume its snapshot.
                logic w_unused_snap;
                assign w_unused_snap = ^r_snap;
            end
        end
    endgenerate

    assign w_advance     = ~g_stage[STAGES-1].r_vld | bus.out_ready;
    assign w_xfer        = g_stage[STAGES-1].r_vld & bus.out_ready;

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.result    = g_stage[STAGES-1].r_res;

    // ------------------------------------------------------------------
    // LED hold register and change pulse
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_led;
    logic              r_changed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led     <= '0;
            r_changed <= 1'b0;
        end else if (w_xfer) begin
            r_led     <= g_stage[STAGES-1].r_res;
            r_changed <= (g_stage[STAGES-1].r_res != r_led);
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign bus.led     = r_led;
    assign bus.changed = r_changed;

endmodule
`default_nettype wire
